fp_sqrt_sched: RTL and testbench
================================

Name: fp_sqrt_sched

Overview:
- Shares one single-precision square-root datapath among NUM_REQ requesters using round-robin arbitration.
- Screens each accepted operand for IEEE special cases and answers those directly, without using the datapath.
- Holds the operand and enable stable for a fixed LATENCY window, captures the result, and returns it with the requester ID over a valid/ready response port.
- One operation is in flight at a time.

Parameters:
- NUM_REQ, 4, number of requesters (>=2). ID_W = $clog2(NUM_REQ) is a localparam.
- LATENCY, 6, cycles from sqrt_en rising with a stable sqrt_a until sqrt_result is valid (>=1).

Ports:
- clk  in  1  clock. All state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request.
- req_operand  in  32*NUM_REQ  flattened operands; requester i uses bits [32*i+31:32*i].
- req_ready  out  NUM_REQ  one-hot accept strobe.
- sqrt_a  out  32  operand to the datapath.
- sqrt_en  out  1  datapath enable.
- sqrt_result  in  32  datapath result.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer accept.
- rsp_id  out  ID_W  index of the requester being answered.
- rsp_result  out  32  square-root result.
- rsp_invalid  out  1  set for an invalid operation (negative non-zero operand or signalling NaN).

Behaviour:
- Reset (async, any state):
  - state=IDLE; rsp_valid=0, rsp_result=0, rsp_id=0, rsp_invalid=0, sqrt_en=0, sqrt_a=0 (operand register cleared).
  - Round-robin pointer last_grant=NUM_REQ-1, so requester 0 wins first.
  - An in-flight operation is discarded and no response is produced.
- req_ready is combinational. It is non-zero only in IDLE, when at least one req_valid is high. It is one-hot on the first requester with req_valid high, searching from last_grant+1 with wrap-around.
- Accept cycle T (IDLE with a grant g):
  - Register the operand, id=g, last_grant=g.
  - Classify the operand using its exponent and mantissa fields.
- Special cases go to RESP at T+1; sqrt_en stays 0:
  - exp==0 (zero or denormal, flushed) -> {sign,31'b0}, invalid=0.
  - +inf (0x7F800000) -> 0x7F800000, invalid=0.
  - NaN (exp==FF, mant!=0) -> 0x7FC00000; invalid=1 only for a signalling NaN (mant[22]==0).
  - sign=1 with a non-zero finite value or -inf -> 0x7FC00000, invalid=1.
- Normal operand goes to WAIT at T+1:
  - Load counter cnt=LATENCY-1; sqrt_en=1; sqrt_a=operand register, held constant.
  - Each cycle in WAIT: if cnt==0, capture sqrt_result into rsp_result (invalid=0), set sqrt_en=0, go to RESP; otherwise decrement cnt.
  - Resulting latency: rsp_valid high at T+1+LATENCY.
- RESP:
  - rsp_valid=1; rsp_id, rsp_result and rsp_invalid are held stable while rsp_ready=0 (no timeout).
  - On rsp_valid && rsp_ready: rsp_valid=0, go to IDLE. The next grant is possible in the following cycle, never in the same cycle.
- Simultaneous events:
  - req_valid may drop without having been granted; that requester is simply skipped.
  - req_valid changes during WAIT or RESP are ignored.
  - req_ready is never high outside IDLE.
- Throughput: normal operations at most one per LATENCY+2 cycles; special cases one per 2 cycles when rsp_ready is held high.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1,0,...
- The counter and ID are sized so that no wrap or overflow is reachable.

Test Plan (defaults NUM_REQ=4, LATENCY=6; the model answers with the true sqrt at the LATENCY boundary and garbage before it):
- Normal operand: req 2 sends 0x40800000 (4.0), accepted at T -> sqrt_en high T+1..T+6, sqrt_a stable; at T+7 rsp_valid=1, rsp_id=2, rsp_result=0x40000000, rsp_invalid=0.
- Round-robin rotation: all four req_valid held high, rsp_ready=1 -> grant order 0,1,2,3,0; each req_ready is a single-cycle one-hot pulse.
- Special operands:
  - 0xC0800000 (-4.0) -> at T+1 rsp_result=0x7FC00000, rsp_invalid=1, sqrt_en never 1.
  - 0x7F800000 -> 0x7F800000, invalid=0.
  - 0x80000000 -> 0x80000000, invalid=0.
  - 0x7F800001 -> 0x7FC00000, invalid=1.
- Backpressure: rsp_ready=0 for 10 cycles in RESP -> rsp_* stable, req_ready=0 throughout; release -> IDLE, next grant one cycle later.
- Reset mid-WAIT: rst pulsed at T+3 -> all outputs 0 immediately, no response; after release, the first grant goes to requester 0.
- Skip on drop: req 1 deasserts before its turn while 0 and 2 stay valid -> grants 0 then 2.

Source files
------------

// File: rtl/fp_sqrt_sched.sv
// fp_sqrt_sched: round-robin scheduler sharing one single-precision square-root
// datapath among NUM_REQ requesters. IEEE special operands are answered
// directly; normal operands are held on the datapath for LATENCY cycles.
module fp_sqrt_sched #(
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [32*NUM_REQ-1:0]      req_operand,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [31:0]                sqrt_a,
  output logic                       sqrt_en,
  input  logic [31:0]                sqrt_result,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [31:0]                rsp_result,
  output logic                       rsp_invalid
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic [31:0] PINF = 32'h7F80_0000;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef struct packed {
    logic        special;
    logic        invalid;
    logic [31:0] result;
  } class_t;

  // Decide whether an operand bypasses the datapath, and what it answers.
  function automatic class_t classify(input logic [31:0] op);
    class_t c;
    c = '{special: 1'b1, invalid: 1'b0, result: 32'h0};
    if (op[30:23] == 8'h00) begin
      c.result = {op[31], 31'b0};              // zero / flushed denormal keeps sign
    end else if (op[30:23] == 8'hFF && op[22:0] != 23'h0) begin
      c.result  = QNAN;
      c.invalid = ~op[22];                     // only a signalling NaN is invalid
    end else if (op[31]) begin
      c.result  = QNAN;                        // negative finite or -inf
      c.invalid = 1'b1;
    end else if (op[30:23] == 8'hFF) begin
      c.result = PINF;
    end else begin
      c.special = 1'b0;
    end
    return c;
  endfunction

  state_t            state_q, state_d;
  logic [ID_W-1:0]   last_grant_q, last_grant_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [31:0]       opnd_q, opnd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sqrt_en_q, sqrt_en_d;
  logic [31:0]       rsp_result_q, rsp_result_d;
  logic              rsp_invalid_q, rsp_invalid_d;

  logic              grant_any;
  logic [ID_W-1:0]   grant_idx;
  logic [31:0]       grant_op;
  class_t            grant_cls;

  // Round-robin search starting just after the last granted requester.
  always_comb begin : grant_search
    int idx;
    idx       = 0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant_q) + k) % NUM_REQ;
      if (!grant_any && req_valid[idx]) begin
        grant_any = 1'b1;
        grant_idx = ID_W'(idx);
      end
    end
    grant_op  = req_operand[32*int'(grant_idx) +: 32];
    grant_cls = classify(grant_op);
    req_ready = (state_q == IDLE && grant_any) ? (NUM_REQ'(1) << grant_idx) : '0;
  end

  // Next-state logic for the accept / wait / respond sequence.
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    id_d          = id_q;
    opnd_d        = opnd_q;
    cnt_d         = cnt_q;
    sqrt_en_d     = sqrt_en_q;
    rsp_result_d  = rsp_result_q;
    rsp_invalid_d = rsp_invalid_q;
    case (state_q)
      IDLE: begin
        if (grant_any) begin
          opnd_d       = grant_op;
          id_d         = grant_idx;
          last_grant_d = grant_idx;
          if (grant_cls.special) begin
            rsp_result_d  = grant_cls.result;
            rsp_invalid_d = grant_cls.invalid;
            state_d       = RESP;
          end else begin
            cnt_d     = CNT_W'(LATENCY - 1);
            sqrt_en_d = 1'b1;
            state_d   = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          rsp_result_d  = sqrt_result;
          rsp_invalid_d = 1'b0;
          sqrt_en_d     = 1'b0;
          state_d       = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset discards any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      last_grant_q  <= ID_W'(NUM_REQ - 1);
      id_q          <= '0;
      opnd_q        <= '0;
      cnt_q         <= '0;
      sqrt_en_q     <= 1'b0;
      rsp_result_q  <= '0;
      rsp_invalid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      id_q          <= id_d;
      opnd_q        <= opnd_d;
      cnt_q         <= cnt_d;
      sqrt_en_q     <= sqrt_en_d;
      rsp_result_q  <= rsp_result_d;
      rsp_invalid_q <= rsp_invalid_d;
    end
  end

  assign sqrt_a      = opnd_q;
  assign sqrt_en     = sqrt_en_q;
  assign rsp_valid   = (state_q == RESP);
  assign rsp_id      = id_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_invalid = rsp_invalid_q;

endmodule

// File: tb/tb_fp_sqrt_sched.sv
// Testbench for fp_sqrt_sched: behavioural datapath plus a high-level
// arbitration/classification reference model.
module tb_fp_sqrt_sched;
  localparam int NUM_REQ = 4;
  localparam int LATENCY = 6;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic [31:0] PINF = 32'h7F80_0000;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [127:0] req_operand;
  logic [3:0]   req_ready;
  logic [31:0]  sqrt_a;
  logic         sqrt_en;
  logic [31:0]  sqrt_result;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [1:0]   rsp_id;
  logic [31:0]  rsp_result;
  logic         rsp_invalid;

  int n_checks = 0;
  int n_fail   = 0;
  int mdl_last = NUM_REQ - 1;
  int en_cnt;

  fp_sqrt_sched #(.NUM_REQ(NUM_REQ), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_operand(req_operand),
    .req_ready(req_ready), .sqrt_a(sqrt_a), .sqrt_en(sqrt_en),
    .sqrt_result(sqrt_result), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_invalid(rsp_invalid)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  // Datapath answer: exact roots for a few perfect squares, otherwise a fixed scramble.
  function automatic logic [31:0] dp_true(input logic [31:0] x);
    case (x)
      32'h4080_0000: return 32'h4000_0000; // 4    -> 2
      32'h3F80_0000: return 32'h3F80_0000; // 1    -> 1
      32'h4180_0000: return 32'h4080_0000; // 16   -> 4
      32'h4110_0000: return 32'h4040_0000; // 9    -> 3
      32'h3E80_0000: return 32'h3F00_0000; // 0.25 -> 0.5
      32'h4010_0000: return 32'h3FC0_0000; // 2.25 -> 1.5
      default:       return {1'b0, x[30:0]} ^ 32'h0015_A5A5;
    endcase
  endfunction

  // Datapath model: garbage until sqrt_en has been high for LATENCY cycles.
  always @(posedge clk) begin
    if (rst || !sqrt_en) en_cnt <= 0;
    else                 en_cnt <= en_cnt + 1;
  end
  assign sqrt_result = (sqrt_en && en_cnt >= LATENCY - 1) ? dp_true(sqrt_a)
                                                          : (32'hDEAD_0000 | 32'(en_cnt));

  function automatic int mdl_pick(input logic [3:0] v);
    int i;
    for (int k = 1; k <= NUM_REQ; k++) begin
      i = (mdl_last + k) % NUM_REQ;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic void mdl_special(input logic [31:0] op, output bit sp,
                                      output logic [31:0] res, output bit inv);
    logic [7:0]  e;
    logic [22:0] m;
    e = op[30:23]; m = op[22:0];
    sp = 1'b1; inv = 1'b0; res = 32'h0;
    if (e == 8'h00)                 res = {op[31], 31'b0};
    else if (e == 8'hFF && m != 0)  begin res = QNAN; inv = !m[22]; end
    else if (op[31])                begin res = QNAN; inv = 1'b1; end
    else if (e == 8'hFF)            res = PINF;
    else                            begin sp = 1'b0; res = dp_true(op); end
  endfunction

  task automatic wait_grant(input int maxc, output logic [3:0] rr, output bit ok);
    ok = 1'b0; rr = '0;
    for (int c = 0; c < maxc; c++) begin
      #1;
      if (req_ready != 0) begin rr = req_ready; ok = 1'b1; return; end
      @(negedge clk);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    mdl_last = NUM_REQ - 1;
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    n_checks++; if (rsp_result !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_result got=%h exp=0", rsp_result); end
    n_checks++; if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL reset_rsp_id got=%0d exp=0", rsp_id); end
    n_checks++; if (rsp_invalid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_invalid got=%b exp=0", rsp_invalid); end
    n_checks++; if (sqrt_en !== 1'b0) begin n_fail++; $display("FAIL reset_sqrt_en got=%b exp=0", sqrt_en); end
    n_checks++; if (sqrt_a !== 32'h0) begin n_fail++; $display("FAIL reset_sqrt_a got=%h exp=0", sqrt_a); end
    n_checks++; if (req_ready !== 4'h0) begin n_fail++; $display("FAIL reset_req_ready got=%b exp=0", req_ready); end
    rst = 1'b0;
    mdl_last = NUM_REQ - 1;
  endtask

  task automatic test_normal();
    logic [31:0] tbl [6] = '{32'h3F80_0000, 32'h4180_0000, 32'h4110_0000,
                             32'h3E80_0000, 32'h4010_0000, 32'h4080_0000};
    logic [31:0] op;
    logic [3:0]  rr;
    bit ok;
    int r, g;
    for (int n = 0; n < 7; n++) begin
      r  = (n == 0) ? 2 : int'($urandom_range(0, 3));
      if (n == 0)          op = 32'h4080_0000;
      else if (n % 2 == 1) op = tbl[$urandom_range(0, 5)];
      else                 op = {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
      @(negedge clk);
      req_valid = 4'b1 << r;
      req_operand[32*r +: 32] = op;
      g = mdl_pick(req_valid);
      wait_grant(4, rr, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL normal_grant_timeout req=%0d", r); req_valid = '0; return; end
      n_checks++; if (rr !== (4'b1 << g)) begin n_fail++; $display("FAIL normal_grant got=%b exp=%b", rr, 4'b1 << g); end
      mdl_last = g;
      for (int k = 1; k <= LATENCY; k++) begin
        @(negedge clk); req_valid = '0; #1;
        n_checks++; if (sqrt_en !== 1'b1) begin n_fail++; $display("FAIL normal_sqrt_en k=%0d got=%b exp=1", k, sqrt_en); end
        n_checks++; if (sqrt_a !== op) begin n_fail++; $display("FAIL normal_sqrt_a k=%0d got=%h exp=%h", k, sqrt_a, op); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL normal_early_rsp k=%0d got=%b exp=0", k, rsp_valid); end
      end
      @(negedge clk); #1;
      n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL normal_rsp_valid got=%b exp=1", rsp_valid); end
      n_checks++; if (rsp_id !== 2'(g)) begin n_fail++; $display("FAIL normal_rsp_id got=%0d exp=%0d", rsp_id, g); end
      n_checks++; if (rsp_result !== dp_true(op)) begin n_fail++; $display("FAIL normal_rsp_result op=%h got=%h exp=%h", op, rsp_result, dp_true(op)); end
      n_checks++; if (rsp_invalid !== 1'b0) begin n_fail++; $display("FAIL normal_rsp_invalid got=%b exp=0", rsp_invalid); end
      n_checks++; if (sqrt_en !== 1'b0) begin n_fail++; $display("FAIL normal_en_drop got=%b exp=0", sqrt_en); end
      rsp_ready = 1'b1;
      @(negedge clk); rsp_ready = 1'b0; #1;
      n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL normal_rsp_release got=%b exp=0", rsp_valid); end
    end
  endtask

  task automatic test_special();
    logic [31:0] tbl [11] = '{32'hC080_0000, 32'h7F80_0000, 32'h8000_0000, 32'h7F80_0001,
                              32'h0000_0000, 32'h0040_0000, 32'h807F_FFFF, 32'h7FC0_0000,
                              32'hFF80_0000, 32'hFFC0_0001, 32'hBF80_0000};
    logic [31:0] op, eres;
    logic [3:0]  rr;
    bit ok, sp, einv;
    int r, g;
    for (int n = 0; n < 17; n++) begin
      if (n < 11) op = tbl[n];
      else begin
        op = $urandom;
        case ($urandom_range(0, 2))
          0:       op[30:23] = 8'h00;
          1:       op[30:23] = 8'hFF;
          default: begin op[31] = 1'b1; op[30:23] = 8'($urandom_range(1, 254)); end
        endcase
      end
      mdl_special(op, sp, eres, einv);
      r = int'($urandom_range(0, 3));
      @(negedge clk);
      req_valid = 4'b1 << r;
      req_operand[32*r +: 32] = op;
      g = mdl_pick(req_valid);
      wait_grant(4, rr, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL special_grant_timeout op=%h", op); req_valid = '0; return; end
      n_checks++; if (rr !== (4'b1 << g)) begin n_fail++; $display("FAIL special_grant got=%b exp=%b", rr, 4'b1 << g); end
      mdl_last = g;
      @(negedge clk); req_valid = '0; #1;
      n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL special_rsp_valid op=%h got=%b exp=1", op, rsp_valid); end
      n_checks++; if (rsp_result !== eres) begin n_fail++; $display("FAIL special_result op=%h got=%h exp=%h", op, rsp_result, eres); end
      n_checks++; if (rsp_invalid !== einv) begin n_fail++; $display("FAIL special_invalid op=%h got=%b exp=%b", op, rsp_invalid, einv); end
      n_checks++; if (rsp_id !== 2'(g)) begin n_fail++; $display("FAIL special_id got=%0d exp=%0d", rsp_id, g); end
      n_checks++; if (sqrt_en !== 1'b0) begin n_fail++; $display("FAIL special_sqrt_en op=%h got=%b exp=0", op, sqrt_en); end
      rsp_ready = 1'b1;
      @(negedge clk); rsp_ready = 1'b0; #1;
      n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL special_release got=%b exp=0", rsp_valid); end
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] rr;
    bit ok;
    int g;
    pulse_reset();
    for (int i = 0; i < NUM_REQ; i++) req_operand[32*i +: 32] = PINF;
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    for (int n = 0; n < 9; n++) begin
      g = mdl_pick(req_valid);
      wait_grant(n == 0 ? 2 : 1, rr, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL rr_grant_timeout n=%0d", n); break; end
      n_checks++; if (rr !== (4'b1 << g)) begin n_fail++; $display("FAIL rr_grant n=%0d got=%b exp=%b", n, rr, 4'b1 << g); end
      mdl_last = g;
      @(negedge clk); #1;
      n_checks++; if (req_ready !== 4'h0) begin n_fail++; $display("FAIL rr_pulse n=%0d got=%b exp=0", n, req_ready); end
      n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(g)) begin n_fail++; $display("FAIL rr_rsp n=%0d valid=%b id=%0d exp_id=%0d", n, rsp_valid, rsp_id, g); end
      if (n == 8) req_valid = '0;
      @(negedge clk);
    end
    req_valid = '0;
    @(negedge clk); rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [3:0] rr;
    bit ok;
    int g;
    for (int i = 0; i < NUM_REQ; i++) req_operand[32*i +: 32] = PINF;
    req_operand[32*3 +: 32] = 32'hFF80_0000;
    @(negedge clk);
    req_valid = 4'b1000;
    g = mdl_pick(req_valid);
    wait_grant(4, rr, ok);
    n_checks++; if (!ok || rr !== (4'b1 << g)) begin n_fail++; $display("FAIL bp_grant got=%b exp=%b", rr, 4'b1 << g); req_valid = '0; return; end
    mdl_last = g;
    @(negedge clk); req_valid = 4'hF;
    for (int c = 0; c < 10; c++) begin
      #1;
      n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(g) || rsp_result !== QNAN || rsp_invalid !== 1'b1)
        begin n_fail++; $display("FAIL bp_hold c=%0d valid=%b id=%0d result=%h invalid=%b", c, rsp_valid, rsp_id, rsp_result, rsp_invalid); end
      n_checks++; if (req_ready !== 4'h0) begin n_fail++; $display("FAIL bp_req_ready c=%0d got=%b exp=0", c, req_ready); end
      @(negedge clk);
    end
    rsp_ready = 1'b1; #1;
    n_checks++; if (rsp_valid !== 1'b1 || req_ready !== 4'h0) begin n_fail++; $display("FAIL bp_release_cycle valid=%b ready=%b", rsp_valid, req_ready); end
    @(negedge clk); rsp_ready = 1'b0; #1;
    g = mdl_pick(req_valid);
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_idle got=%b exp=0", rsp_valid); end
    n_checks++; if (req_ready !== (4'b1 << g)) begin n_fail++; $display("FAIL bp_next_grant got=%b exp=%b", req_ready, 4'b1 << g); end
    mdl_last = g;
    @(negedge clk); req_valid = '0; rsp_ready = 1'b1; #1;
    n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(g)) begin n_fail++; $display("FAIL bp_next_rsp valid=%b id=%0d exp_id=%0d", rsp_valid, rsp_id, g); end
    @(negedge clk); rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    logic [3:0] rr;
    bit ok;
    int g;
    @(negedge clk);
    req_valid = 4'b0010;
    req_operand[32*1 +: 32] = 32'h4180_0000;
    g = mdl_pick(req_valid);
    wait_grant(4, rr, ok);
    n_checks++; if (!ok || rr !== (4'b1 << g)) begin n_fail++; $display("FAIL rmw_grant got=%b exp=%b", rr, 4'b1 << g); req_valid = '0; return; end
    @(negedge clk); req_valid = '0;
    @(negedge clk);
    @(negedge clk); #1;
    n_checks++; if (sqrt_en !== 1'b1) begin n_fail++; $display("FAIL rmw_in_wait got=%b exp=1", sqrt_en); end
    rst = 1'b1; #1;
    n_checks++; if (sqrt_en !== 1'b0 || sqrt_a !== 32'h0 || rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_result !== 32'h0 || rsp_invalid !== 1'b0)
      begin n_fail++; $display("FAIL rmw_async_clear en=%b a=%h valid=%b id=%0d result=%h invalid=%b", sqrt_en, sqrt_a, rsp_valid, rsp_id, rsp_result, rsp_invalid); end
    mdl_last = NUM_REQ - 1;
    @(negedge clk); rst = 1'b0;
    for (int c = 0; c < LATENCY + 3; c++) begin
      @(negedge clk); #1;
      n_checks++; if (rsp_valid !== 1'b0 || sqrt_en !== 1'b0) begin n_fail++; $display("FAIL rmw_no_rsp c=%0d valid=%b en=%b", c, rsp_valid, sqrt_en); end
    end
    for (int i = 0; i < NUM_REQ; i++) req_operand[32*i +: 32] = PINF;
    req_valid = 4'hF; #1;
    g = mdl_pick(req_valid);
    n_checks++; if (req_ready !== (4'b1 << g)) begin n_fail++; $display("FAIL rmw_first_grant got=%b exp=%b", req_ready, 4'b1 << g); end
    mdl_last = g;
    @(negedge clk); req_valid = '0; rsp_ready = 1'b1;
    @(negedge clk); rsp_ready = 1'b0;
  endtask

  task automatic test_skip_drop();
    logic [3:0] rr;
    bit ok;
    int g;
    pulse_reset();
    for (int i = 0; i < NUM_REQ; i++) req_operand[32*i +: 32] = 32'h8000_0000;
    req_valid = 4'b0111;
    g = mdl_pick(req_valid);
    wait_grant(2, rr, ok);
    n_checks++; if (!ok || rr !== (4'b1 << g)) begin n_fail++; $display("FAIL skip_first got=%b exp=%b", rr, 4'b1 << g); end
    mdl_last = g;
    @(negedge clk); req_valid = 4'b0101; rsp_ready = 1'b1; #1;
    n_checks++; if (rsp_id !== 2'(g)) begin n_fail++; $display("FAIL skip_first_id got=%0d exp=%0d", rsp_id, g); end
    @(negedge clk); #1;
    g = mdl_pick(req_valid);
    n_checks++; if (req_ready !== (4'b1 << g)) begin n_fail++; $display("FAIL skip_second got=%b exp=%b", req_ready, 4'b1 << g); end
    mdl_last = g;
    @(negedge clk); req_valid = '0; #1;
    n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(g)) begin n_fail++; $display("FAIL skip_second_rsp valid=%b id=%0d exp_id=%0d", rsp_valid, rsp_id, g); end
    @(negedge clk); rsp_ready = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    req_valid   = '0;
    req_operand = '0;
    rsp_ready   = 1'b0;
    test_reset();
    test_normal();
    test_special();
    test_round_robin();
    test_backpressure();
    test_reset_mid_wait();
    test_skip_drop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
